// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS branch-resolution control slice: FSM states,
// branch op codes, condition-mux select codes and the ALU compare operation.
package mips_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [2:0] {
    BR_BEQ = 3'b000,
    BR_BNE = 3'b001,
    BR_BGT = 3'b010,
    BR_BLE = 3'b011
  } br_op_e;

  localparam logic [1:0] SEL_NOTZERO = 2'b00;
  localparam logic [1:0] SEL_ZERO    = 2'b01;
  localparam logic [1:0] SEL_MAIOR   = 2'b10;
  localparam logic [1:0] SEL_OU      = 2'b11;

  localparam logic [2:0] ALU_SUB = 3'b010;

  // Maps a legal branch op onto the condition wire that decides it.
  function automatic logic [1:0] sel_for_op(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      BR_BEQ:  sel = SEL_ZERO;
      BR_BNE:  sel = SEL_NOTZERO;
      BR_BGT:  sel = SEL_MAIOR;
      BR_BLE:  sel = SEL_OU;
      default: sel = SEL_NOTZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/branch_cond_ctrl_if.sv
// Bundle between the main control FSM / datapath and the branch sequencer.
// The sequencer takes the slave side.
interface branch_cond_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [2:0]       branch_op;
  logic             zero_in;
  logic             greater_in;
  logic             PCWriteFio;
  logic [2:0]       alu_ctrl;
  logic             NotZeroFio;
  logic             ZeroFio;
  logic             MaiorFio;
  logic             OuFio;
  logic [1:0]       PCWriteCondMux;
  logic             PCWriteCond;
  logic             busy;
  logic             done;
  logic             branch_taken;
  logic             illegal_op;
  logic [CNT_W-1:0] taken_count;

  modport slave (
    input  start, branch_op, zero_in, greater_in, PCWriteFio,
    output alu_ctrl, NotZeroFio, ZeroFio, MaiorFio, OuFio, PCWriteCondMux,
           PCWriteCond, busy, done, branch_taken, illegal_op, taken_count
  );

  modport master (
    output start, branch_op, zero_in, greater_in, PCWriteFio,
    input  alu_ctrl, NotZeroFio, ZeroFio, MaiorFio, OuFio, PCWriteCondMux,
           PCWriteCond, busy, done, branch_taken, illegal_op, taken_count
  );
endinterface

// File: rtl/branch_cond_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count register: increments on inc unless already saturated.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_cond_ctrl.sv
// Multicycle branch-resolution sequencer: compare via ALU, latch flags, drive
// the PC-write condition mux, then report the read-back decision.
module branch_cond_ctrl #(
  parameter int         CNT_W   = 16,
  parameter logic [2:0] ALU_SUB = mips_ctrl_pkg::ALU_SUB
) (
  input logic              clock,
  input logic              reset,
  branch_cond_ctrl_if.slave bus
);
  import mips_ctrl_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             illegal_d;
  logic             zero_q, greater_q;
  logic             branch_taken_q;
  logic [2:0]       alu_ctrl_q;
  logic             busy_q, done_q, illegal_q, pcwc_q;
  logic [1:0]       mux_q;
  logic             inc_s;
  logic [CNT_W-1:0] count_s;

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.branch_op <= BR_BLE) begin
            op_d    = bus.branch_op;
            state_d = ST_COMPARE;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, flags and outputs; outputs are precomputed from state_d so they
  // line up with the state they describe without a combinational path.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      op_q           <= 3'b000;
      zero_q         <= 1'b0;
      greater_q      <= 1'b0;
      branch_taken_q <= 1'b0;
      alu_ctrl_q     <= 3'b000;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      pcwc_q         <= 1'b0;
      mux_q          <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_ctrl_q <= (state_d == ST_COMPARE) ? ALU_SUB : 3'b000;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      illegal_q  <= illegal_d;
      pcwc_q     <= (state_d == ST_RESOLVE);
      if (state_q == ST_COMPARE) begin
        zero_q    <= bus.zero_in;
        greater_q <= bus.greater_in;
      end
      if (state_q == ST_RESOLVE) begin
        branch_taken_q <= bus.PCWriteFio;
      end
      // The select persists after RESOLVE; consumers qualify it with PCWriteCond.
      if (state_d == ST_RESOLVE) begin
        mux_q <= sel_for_op(op_q);
      end
    end
  end

  assign inc_s = (state_q == ST_RESOLVE) && bus.PCWriteFio;

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_s),
    .count (count_s)
  );

  assign bus.alu_ctrl       = alu_ctrl_q;
  assign bus.NotZeroFio     = ~zero_q;
  assign bus.ZeroFio        = zero_q;
  assign bus.MaiorFio       = greater_q;
  assign bus.OuFio          = zero_q | ~greater_q;
  assign bus.PCWriteCondMux = mux_q;
  assign bus.PCWriteCond    = pcwc_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.branch_taken   = branch_taken_q;
  assign bus.illegal_op     = illegal_q;
  assign bus.taken_count    = count_s;

endmodule

// File: tb/tb_branch_cond_ctrl.sv
// Directed bench for branch_cond_ctrl; a narrow-counter second instance covers saturation.
module tb_branch_cond_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_cond_ctrl_if #(.CNT_W(16)) bif ();
  branch_cond_ctrl_if #(.CNT_W(2))  sif ();

  always #5 clk = ~clk;

  // Condition-mux models closing the loop back into PCWriteFio
  assign bif.PCWriteFio = (bif.PCWriteCondMux == 2'b00) ? bif.NotZeroFio :
                          (bif.PCWriteCondMux == 2'b01) ? bif.ZeroFio :
                          (bif.PCWriteCondMux == 2'b10) ? bif.MaiorFio : bif.OuFio;
  assign sif.PCWriteFio = (sif.PCWriteCondMux == 2'b00) ? sif.NotZeroFio :
                          (sif.PCWriteCondMux == 2'b01) ? sif.ZeroFio :
                          (sif.PCWriteCondMux == 2'b10) ? sif.MaiorFio : sif.OuFio;

  branch_cond_ctrl #(.CNT_W(16)) dut (.clock(clk), .reset(rst_n), .bus(bif));
  branch_cond_ctrl #(.CNT_W(2))  dut_sat (.clock(clk), .reset(rst_n), .bus(sif));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one start cycle, then drop start; returns in the first busy cycle.
  task automatic launch(input logic [2:0] op, input logic z, input logic g);
    bif.branch_op = op; bif.zero_in = z; bif.greater_in = g; bif.start = 1'b1;
    tick;
    bif.start = 1'b0;
  endtask

  task automatic test_reset;
    bif.start = 1'b0; bif.branch_op = 3'b000; bif.zero_in = 1'b0; bif.greater_in = 1'b0;
    sif.start = 1'b0; sif.branch_op = 3'b000; sif.zero_in = 1'b0; sif.greater_in = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bif.busy); end
    n_cmp++; if (bif.taken_count !== 16'h0000) begin n_bad++; $display("FAIL rst_count: got %h want 0000", bif.taken_count); end
    n_cmp++; if (bif.PCWriteCondMux !== 2'b00) begin n_bad++; $display("FAIL rst_mux: got %b want 00", bif.PCWriteCondMux); end
    n_cmp++; if (bif.alu_ctrl !== 3'b000) begin n_bad++; $display("FAIL rst_alu: got %b want 000", bif.alu_ctrl); end
    n_cmp++; if ({bif.NotZeroFio, bif.ZeroFio, bif.MaiorFio, bif.OuFio} !== 4'b1001) begin n_bad++;
      $display("FAIL rst_wires: got %b want 1001", {bif.NotZeroFio, bif.ZeroFio, bif.MaiorFio, bif.OuFio}); end
    n_cmp++; if ({bif.done, bif.branch_taken, bif.illegal_op, bif.PCWriteCond} !== 4'b0000) begin n_bad++;
      $display("FAIL rst_flags: got %b want 0000", {bif.done, bif.branch_taken, bif.illegal_op, bif.PCWriteCond}); end
    // Reset while in COMPARE with flags that would otherwise be captured
    launch(3'b000, 1'b1, 1'b1);
    n_cmp++; if (bif.alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL cmp_alu: got %b want 010", bif.alu_ctrl); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_cmp++; if ({bif.busy, bif.PCWriteCond, bif.done} !== 3'b000) begin n_bad++;
      $display("FAIL midrst_ctl: got %b want 000", {bif.busy, bif.PCWriteCond, bif.done}); end
    n_cmp++; if ({bif.NotZeroFio, bif.OuFio, bif.taken_count} !== {2'b11, 16'h0000}) begin n_bad++;
      $display("FAIL midrst_wires: got %b_%b_%h want 1_1_0000", bif.NotZeroFio, bif.OuFio, bif.taken_count); end
    tick; tick;
    n_cmp++; if ({bif.busy, bif.done, bif.PCWriteCond} !== 3'b000) begin n_bad++;
      $display("FAIL midrst_idle: got %b want 000", {bif.busy, bif.done, bif.PCWriteCond}); end
  endtask

  task automatic test_beq;
    launch(3'b000, 1'b1, 1'b0);
    n_cmp++; if ({bif.busy, bif.done, bif.alu_ctrl} !== 5'b10_010) begin n_bad++;
      $display("FAIL beq_compare: got %b want 10010", {bif.busy, bif.done, bif.alu_ctrl}); end
    tick;
    n_cmp++; if ({bif.PCWriteCondMux, bif.PCWriteCond, bif.PCWriteFio} !== 4'b01_1_1) begin n_bad++;
      $display("FAIL beq_resolve: got %b want 0111", {bif.PCWriteCondMux, bif.PCWriteCond, bif.PCWriteFio}); end
    tick;
    n_cmp++; if ({bif.done, bif.branch_taken, bif.PCWriteCond, bif.taken_count} !== {3'b110, 16'd1}) begin n_bad++;
      $display("FAIL beq_done: got %b_%0d want 110_1", {bif.done, bif.branch_taken, bif.PCWriteCond}, bif.taken_count); end
    tick;
    n_cmp++; if ({bif.done, bif.busy, bif.PCWriteCondMux} !== 4'b00_01) begin n_bad++;
      $display("FAIL beq_after: got %b want 0001", {bif.done, bif.busy, bif.PCWriteCondMux}); end
  endtask

  task automatic test_bne_bgt;
    launch(3'b001, 1'b1, 1'b0);
    tick;
    n_cmp++; if ({bif.PCWriteCondMux, bif.PCWriteCond, bif.PCWriteFio} !== 4'b00_1_0) begin n_bad++;
      $display("FAIL bne_resolve: got %b want 0010", {bif.PCWriteCondMux, bif.PCWriteCond, bif.PCWriteFio}); end
    tick;
    n_cmp++; if ({bif.done, bif.branch_taken, bif.taken_count} !== {2'b10, 16'd1}) begin n_bad++;
      $display("FAIL bne_done: got %b_%0d want 10_1", {bif.done, bif.branch_taken}, bif.taken_count); end
    tick;
    launch(3'b010, 1'b0, 1'b1);
    tick;
    n_cmp++; if ({bif.PCWriteCondMux, bif.PCWriteCond, bif.MaiorFio} !== 4'b10_1_1) begin n_bad++;
      $display("FAIL bgt_resolve: got %b want 1011", {bif.PCWriteCondMux, bif.PCWriteCond, bif.MaiorFio}); end
    tick;
    n_cmp++; if ({bif.done, bif.branch_taken, bif.taken_count} !== {2'b11, 16'd2}) begin n_bad++;
      $display("FAIL bgt_done: got %b_%0d want 11_2", {bif.done, bif.branch_taken}, bif.taken_count); end
    tick;
  endtask

  task automatic test_ble;
    launch(3'b011, 1'b0, 1'b1);
    tick;
    n_cmp++; if ({bif.PCWriteCondMux, bif.PCWriteCond, bif.OuFio} !== 4'b11_1_0) begin n_bad++;
      $display("FAIL ble_nt_resolve: got %b want 1110", {bif.PCWriteCondMux, bif.PCWriteCond, bif.OuFio}); end
    tick;
    n_cmp++; if ({bif.done, bif.branch_taken, bif.taken_count} !== {2'b10, 16'd2}) begin n_bad++;
      $display("FAIL ble_nt_done: got %b_%0d want 10_2", {bif.done, bif.branch_taken}, bif.taken_count); end
    tick;
    launch(3'b011, 1'b0, 1'b0);
    tick;
    n_cmp++; if ({bif.PCWriteCondMux, bif.PCWriteCond, bif.OuFio} !== 4'b11_1_1) begin n_bad++;
      $display("FAIL ble_t_resolve: got %b want 1111", {bif.PCWriteCondMux, bif.PCWriteCond, bif.OuFio}); end
    tick;
    n_cmp++; if ({bif.done, bif.branch_taken, bif.taken_count} !== {2'b11, 16'd3}) begin n_bad++;
      $display("FAIL ble_t_done: got %b_%0d want 11_3", {bif.done, bif.branch_taken}, bif.taken_count); end
    tick;
  endtask

  task automatic test_illegal;
    launch(3'b101, 1'b1, 1'b0);
    n_cmp++; if ({bif.done, bif.illegal_op, bif.busy, bif.PCWriteCond, bif.alu_ctrl} !== 7'b1110_000) begin n_bad++;
      $display("FAIL ill_done: got %b want 1110000", {bif.done, bif.illegal_op, bif.busy, bif.PCWriteCond, bif.alu_ctrl}); end
    n_cmp++; if ({bif.branch_taken, bif.taken_count} !== {1'b1, 16'd3}) begin n_bad++;
      $display("FAIL ill_keep: got %b_%0d want 1_3", bif.branch_taken, bif.taken_count); end
    tick;
    n_cmp++; if ({bif.done, bif.illegal_op, bif.busy, bif.PCWriteCond} !== 4'b0000) begin n_bad++;
      $display("FAIL ill_after: got %b want 0000", {bif.done, bif.illegal_op, bif.busy, bif.PCWriteCond}); end
  endtask

  task automatic test_back_to_back;
    int n_done;
    n_done = 0;
    bif.branch_op = 3'b000; bif.zero_in = 1'b1; bif.greater_in = 1'b0; bif.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (i == 12) bif.start = 1'b0;
      if (bif.done === 1'b1) n_done++;
      n_cmp++; if (bif.done !== ((i % 4) == 3)) begin n_bad++;
        $display("FAIL b2b_done_c%0d: got %b want %b", i, bif.done, ((i % 4) == 3)); end
    end
    n_cmp++; if ({n_done, bif.taken_count} !== {32'd3, 16'd6}) begin n_bad++;
      $display("FAIL b2b_total: got %0d ops count %0d want 3 ops count 6", n_done, bif.taken_count); end
    // Start pulse with a different op during COMPARE must be dropped
    launch(3'b000, 1'b1, 1'b0);
    bif.branch_op = 3'b001; bif.start = 1'b1;
    tick;
    bif.start = 1'b0;
    n_cmp++; if (bif.PCWriteCondMux !== 2'b01) begin n_bad++;
      $display("FAIL midop_mux: got %b want 01", bif.PCWriteCondMux); end
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bif.done === 1'b1) n_done++;
    end
    n_cmp++; if ({n_done, bif.taken_count, bif.busy} !== {32'd1, 16'd7, 1'b0}) begin n_bad++;
      $display("FAIL midop_ignored: got %0d ops count %0d busy %b want 1 ops count 7 busy 0", n_done, bif.taken_count, bif.busy); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt;
    for (int k = 0; k < 4; k++) begin
      exp_cnt = (k >= 2) ? 2'b11 : 2'(k + 1);
      sif.branch_op = 3'b000; sif.zero_in = 1'b1; sif.greater_in = 1'b0; sif.start = 1'b1;
      tick;
      sif.start = 1'b0;
      tick; tick;
      n_cmp++; if ({sif.done, sif.branch_taken, sif.taken_count} !== {2'b11, exp_cnt}) begin n_bad++;
        $display("FAIL sat_op%0d: got %b_%b_%0d want 1_1_%0d", k, sif.done, sif.branch_taken, sif.taken_count, exp_cnt); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_beq;
    test_bne_bgt;
    test_ble;
    test_illegal;
    test_back_to_back;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
